// File: rtl/pipe_reg_chain.sv
// Elastic DEPTH-stage register chain with valid/ready handshake. DEPTH cycles of latency.
// Bubbles collapse under a stalled output. Flush and hold gate both handshakes. Empty stages read SET_DATA.
module pipe_reg_chain #(
   parameter int unsigned         DW       = 32,
   parameter int unsigned         DEPTH    = 2,
   parameter logic [DW-1:0]       SET_DATA = DW'(32'h00000013),
   localparam int unsigned        CW       = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush_i,
   input  logic          hold_i,
   input  logic          in_valid_i,
   output logic          in_ready_o,
   input  logic [DW-1:0] data_i,
   output logic          out_valid_o,
   input  logic          out_ready_i,
   output logic [DW-1:0] data_o,
   output logic [CW-1:0] occupancy_o
);

   logic [DEPTH-1:0]         vld_q, vld_d;
   logic [DEPTH-1:0][DW-1:0] dat_q, dat_d;
   logic [CW-1:0]            occ_q, occ_d;
   logic [DEPTH-1:0]         adv;
   logic                     run;
   logic                     in_xfer;
   logic                     out_xfer;

   // adv[k] is true when any stage from k to the output is empty, or the output drains.
   // Flattened per stage so the ready chain has no bit-to-bit combinational feedback.
   always_comb begin
      adv = '0;
      for (int k = 0; k < DEPTH; k++) begin
         logic a;
         a = out_ready_i;
         for (int j = k; j < DEPTH; j++) begin
            a = a | ~vld_q[j];
         end
         adv[k] = a;
      end
   end

   assign run         = ~hold_i & ~flush_i;
   assign in_ready_o  = adv[0] & run & rst;
   assign out_valid_o = vld_q[DEPTH-1] & run;
   assign data_o      = dat_q[DEPTH-1];
   assign occupancy_o = occ_q;
   assign in_xfer     = in_valid_i & in_ready_o;
   assign out_xfer    = out_valid_o & out_ready_i;

   always_comb begin
      vld_d = vld_q;
      dat_d = dat_q;
      occ_d = occ_q;
      if (flush_i) begin
         vld_d = '0;
         dat_d = {DEPTH{SET_DATA}};
         occ_d = '0;
      end else if (!hold_i) begin
         if (adv[0]) begin
            vld_d[0] = in_xfer;
            dat_d[0] = in_xfer ? data_i : SET_DATA;
         end
         for (int k = 1; k < DEPTH; k++) begin
            if (adv[k]) begin
               vld_d[k] = vld_q[k-1];
               dat_d[k] = vld_q[k-1] ? dat_q[k-1] : SET_DATA;
            end
         end
         occ_d = occ_q + CW'(in_xfer) - CW'(out_xfer);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_q <= '0;
         dat_q <= {DEPTH{SET_DATA}};
         occ_q <= '0;
      end else begin
         vld_q <= vld_d;
         dat_q <= dat_d;
         occ_q <= occ_d;
      end
   end

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Directed bench for pipe_reg_chain at DEPTH=3: vector table plus async-reset sequences.
module tb_pipe_reg_chain;

   localparam int          DW  = 32;
   localparam int          DEP = 3;
   localparam logic [31:0] SD  = 32'h00000013;

   logic          clk = 1'b0;
   logic          rst;
   logic          flush_i, hold_i, in_valid_i, out_ready_i;
   logic          in_ready_o, out_valid_o;
   logic [DW-1:0] data_i, data_o;
   logic [1:0]    occupancy_o;

   int errors = 0;
   int checks = 0;

   pipe_reg_chain #(.DW(DW), .DEPTH(DEP), .SET_DATA(SD)) dut (
      .clk         (clk),
      .rst         (rst),
      .flush_i     (flush_i),
      .hold_i      (hold_i),
      .in_valid_i  (in_valid_i),
      .in_ready_o  (in_ready_o),
      .data_i      (data_i),
      .out_valid_o (out_valid_o),
      .out_ready_i (out_ready_i),
      .data_o      (data_o),
      .occupancy_o (occupancy_o)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        iv, ordy, hold, flush;
      logic [31:0] d;
      logic        e_ir, e_ov;
      logic [31:0] e_d;
      logic [1:0]  e_occ;
   } vec_t;

   vec_t tbl[$];

   function automatic vec_t mk(logic iv, logic ordy, logic hold, logic flush, logic [31:0] d,
                               logic e_ir, logic e_ov, logic [31:0] e_d, logic [1:0] e_occ);
      vec_t v;
      v.iv = iv; v.ordy = ordy; v.hold = hold; v.flush = flush; v.d = d;
      v.e_ir = e_ir; v.e_ov = e_ov; v.e_d = e_d; v.e_occ = e_occ;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic chk_all(input string tag, input logic ir, input logic ov,
                          input logic [31:0] d, input logic [1:0] occ);
      chk({tag, " in_ready"},  32'(in_ready_o),  32'(ir));
      chk({tag, " out_valid"}, 32'(out_valid_o), 32'(ov));
      chk({tag, " data_o"},    data_o,           d);
      chk({tag, " occupancy"}, 32'(occupancy_o), 32'(occ));
   endtask

   task automatic drive(input logic iv, input logic ordy, input logic hold,
                        input logic flush, input logic [31:0] d);
      in_valid_i = iv; out_ready_i = ordy; hold_i = hold; flush_i = flush; data_i = d;
   endtask

   initial begin
      // streaming, one item per cycle, latency 3
      tbl.push_back(mk(1,1,0,0,32'h1,  1,0,SD,0));
      tbl.push_back(mk(1,1,0,0,32'h2,  1,0,SD,1));
      tbl.push_back(mk(1,1,0,0,32'h3,  1,0,SD,2));
      tbl.push_back(mk(1,1,0,0,32'h4,  1,1,32'h1,3));
      tbl.push_back(mk(0,1,0,0,32'h0,  1,1,32'h2,3));
      tbl.push_back(mk(0,1,0,0,32'h0,  1,1,32'h3,2));
      tbl.push_back(mk(0,1,0,0,32'h0,  1,1,32'h4,1));
      tbl.push_back(mk(0,1,0,0,32'h0,  1,0,SD,0));
      // back-pressure, bubble collapse, full, simultaneous in/out
      tbl.push_back(mk(1,0,0,0,32'hA,  1,0,SD,0));
      tbl.push_back(mk(1,0,0,0,32'hB,  1,0,SD,1));
      tbl.push_back(mk(1,0,0,0,32'hC,  1,0,SD,2));
      tbl.push_back(mk(1,0,0,0,32'hD,  0,1,32'hA,3));
      tbl.push_back(mk(1,1,0,0,32'hD,  1,1,32'hA,3));
      tbl.push_back(mk(0,1,0,0,32'h0,  1,1,32'hB,3));
      tbl.push_back(mk(0,1,0,0,32'h0,  1,1,32'hC,2));
      tbl.push_back(mk(0,1,0,0,32'h0,  1,1,32'hD,1));
      tbl.push_back(mk(0,0,0,0,32'h0,  1,0,SD,0));
      // flush with a simultaneous offer of 0x55
      tbl.push_back(mk(1,1,0,0,32'h11, 1,0,SD,0));
      tbl.push_back(mk(1,1,0,0,32'h22, 1,0,SD,1));
      tbl.push_back(mk(0,0,0,0,32'h0,  1,0,SD,2));
      tbl.push_back(mk(1,0,0,1,32'h55, 0,0,32'h11,2));
      tbl.push_back(mk(0,0,0,0,32'h0,  1,0,SD,0));
      tbl.push_back(mk(0,1,0,0,32'h0,  1,0,SD,0));
      // hold for three cycles with out_ready high
      tbl.push_back(mk(1,1,0,0,32'h66, 1,0,SD,0));
      tbl.push_back(mk(1,1,0,0,32'h77, 1,0,SD,1));
      tbl.push_back(mk(0,0,0,0,32'h0,  1,0,SD,2));
      tbl.push_back(mk(1,1,1,0,32'h88, 0,0,32'h66,2));
      tbl.push_back(mk(1,1,1,0,32'h88, 0,0,32'h66,2));
      tbl.push_back(mk(1,1,1,0,32'h88, 0,0,32'h66,2));
      tbl.push_back(mk(0,1,0,0,32'h0,  1,1,32'h66,2));
      tbl.push_back(mk(0,1,0,0,32'h0,  1,1,32'h77,1));
      tbl.push_back(mk(0,1,0,0,32'h0,  1,0,SD,0));
      // flush and hold together act as flush
      tbl.push_back(mk(1,1,0,0,32'h99, 1,0,SD,0));
      tbl.push_back(mk(0,1,1,1,32'h0,  0,0,SD,1));
      tbl.push_back(mk(0,1,0,0,32'h0,  1,0,SD,0));

      rst = 1'b0;
      drive(0, 0, 0, 0, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      chk_all("reset", 1'b0, 1'b0, SD, 2'd0);
      rst = 1'b1;
      #1;
      chk("post-reset in_ready", 32'(in_ready_o), 32'd1);
      @(posedge clk); #1;

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].iv, tbl[i].ordy, tbl[i].hold, tbl[i].flush, tbl[i].d);
         #1;
         chk_all($sformatf("vec%0d", i), tbl[i].e_ir, tbl[i].e_ov, tbl[i].e_d, tbl[i].e_occ);
         @(posedge clk); #1;
      end

      // asynchronous reset between edges with the chain full
      drive(1, 0, 0, 0, 32'hA0); @(posedge clk); #1;
      drive(1, 0, 0, 0, 32'hA1); @(posedge clk); #1;
      drive(1, 0, 0, 0, 32'hA2); @(posedge clk); #1;
      drive(0, 0, 0, 0, 32'h0);
      #1;
      chk_all("full before async rst", 1'b0, 1'b1, 32'hA0, 2'd3);
      #2;
      rst = 1'b0;
      #1;
      chk_all("async rst mid-cycle", 1'b0, 1'b0, SD, 2'd0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      drive(0, 1, 0, 0, 32'h0);
      for (int i = 0; i < 4; i++) begin
         #1;
         chk_all($sformatf("after async rst %0d", i), 1'b1, 1'b0, SD, 2'd0);
         @(posedge clk); #1;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
